// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcode encoding and default datapath sizes.
//   DEF_W    : data width
//   DEF_OPW  : opcode width
//   DEF_NREG : architectural register count
//   DEF_RA   : register address width
package cpu_pkg;

    localparam int unsigned DEF_W    = 8;
    localparam int unsigned DEF_OPW  = 3;
    localparam int unsigned DEF_NREG = 8;
    localparam int unsigned DEF_RA   = $clog2(DEF_NREG);

    typedef enum logic [DEF_OPW-1:0] {
        OP_ADD = 3'b000,
        OP_SHR = 3'b001,
        OP_SHL = 3'b010,
        OP_XOR = 3'b011
    } op_e;

endpackage

// File: rtl/operand_fetch_if.sv
// Operand-fetch bus bundle: decoded-instruction input, write-back input,
// and the valid/ready ALU issue slot.
//   slave  : operand_fetch side (consumes in_*/wb_*, drives in_ready/out_*)
//   master : environment side (decoder, write-back stage, ALU)
interface operand_fetch_if import cpu_pkg::*; #(
    parameter int unsigned W    = DEF_W,
    parameter int unsigned OPW  = DEF_OPW,
    parameter int unsigned NREG = DEF_NREG
);
    localparam int unsigned RA = $clog2(NREG);

    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_op;
    logic [RA-1:0]  in_rd;
    logic [RA-1:0]  in_rs1;
    logic [RA-1:0]  in_rs2;
    logic           in_imm_en;
    logic [W-1:0]   in_imm;

    logic           wb_en;
    logic [RA-1:0]  wb_addr;
    logic [W-1:0]   wb_data;

    logic           out_valid;
    logic           out_ready;
    logic [OPW-1:0] out_op;
    logic [W-1:0]   out_a;
    logic [W-1:0]   out_b;
    logic [RA-1:0]  out_rd;

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
        input  wb_en, wb_addr, wb_data,
        input  out_ready,
        output in_ready,
        output out_valid, out_op, out_a, out_b, out_rd
    );

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
        output wb_en, wb_addr, wb_data,
        output out_ready,
        input  in_ready,
        input  out_valid, out_op, out_a, out_b, out_rd
    );

endinterface

// File: rtl/reg_file.sv
// Architectural register file, 2 asynchronous read ports, 1 write port.
// Register 0 reads as zero and ignores writes.
//   clk, rst_n             : clock, async active-low reset (clears all regs)
//   raddr1_i, raddr2_i     : read addresses
//   rdata1_c_o, rdata2_c_o : combinational read data
//   we_i, waddr_i, wdata_i : write port
module reg_file import cpu_pkg::*; #(
    parameter int unsigned W    = DEF_W,
    parameter int unsigned NREG = DEF_NREG,
    localparam int unsigned RA  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RA-1:0] raddr1_i,
    input  logic [RA-1:0] raddr2_i,
    output logic [W-1:0]  rdata1_c_o,
    output logic [W-1:0]  rdata2_c_o,
    input  logic          we_i,
    input  logic [RA-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i
);

    logic [W-1:0] rf_q [NREG];

    // Storage; register 0 is never written so it stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports with register 0 forced to zero.
    always_comb begin
        rdata1_c_o = (raddr1_i == '0) ? '0 : rf_q[raddr1_i];
        rdata2_c_o = (raddr2_i == '0) ? '0 : rf_q[raddr2_i];
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads/bypasses source operands (or substitutes the
// immediate) and issues opcode + operands to the ALU through one registered
// valid/ready slot. Write-back updates the register file and refreshes the
// operands of an instruction stalled in the slot.
//   clk, rst_n : clock, async active-low reset
//   bus        : operand_fetch_if.slave (in_*, wb_*, out_*)
module operand_fetch import cpu_pkg::*; #(
    parameter int unsigned W    = DEF_W,
    parameter int unsigned OPW  = DEF_OPW,
    parameter int unsigned NREG = DEF_NREG
) (
    input  logic            clk,
    input  logic            rst_n,
    operand_fetch_if.slave  bus
);

    localparam int unsigned RA = $clog2(NREG);

    logic [W-1:0]   rf_a;
    logic [W-1:0]   rf_b;
    logic           in_ready;
    logic           accept;
    logic           wb_hit;
    logic [W-1:0]   src_a;
    logic [W-1:0]   src_b;

    logic           valid_q,  valid_d;
    logic [OPW-1:0] op_q,     op_d;
    logic [RA-1:0]  rd_q,     rd_d;
    logic [W-1:0]   a_q,      a_d;
    logic [W-1:0]   b_q,      b_d;
    logic [RA-1:0]  rs1_q,    rs1_d;
    logic [RA-1:0]  rs2_q,    rs2_d;
    logic           imm_en_q, imm_en_d;

    reg_file #(
        .W    (W),
        .NREG (NREG)
    ) u_reg_file (
        .clk        (clk),
        .rst_n      (rst_n),
        .raddr1_i   (bus.in_rs1),
        .raddr2_i   (bus.in_rs2),
        .rdata1_c_o (rf_a),
        .rdata2_c_o (rf_b),
        .we_i       (bus.wb_en),
        .waddr_i    (bus.wb_addr),
        .wdata_i    (bus.wb_data)
    );

    // Slot is free when empty or being drained this cycle.
    assign in_ready     = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && in_ready;
    assign bus.in_ready = in_ready;

    // Same-cycle write-back bypass; wb to r0 never hits.
    always_comb begin
        wb_hit = bus.wb_en && (bus.wb_addr != '0);
        src_a  = (wb_hit && (bus.wb_addr == bus.in_rs1)) ? bus.wb_data : rf_a;
        src_b  = (wb_hit && (bus.wb_addr == bus.in_rs2)) ? bus.wb_data : rf_b;
    end

    // Slot next-state: accept > drain > held-operand refresh.
    always_comb begin
        valid_d  = valid_q;
        op_d     = op_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_en_d = imm_en_q;

        if (accept) begin
            valid_d  = 1'b1;
            op_d     = bus.in_op;
            rd_d     = bus.in_rd;
            a_d      = src_a;
            b_d      = bus.in_imm_en ? bus.in_imm : src_b;
            rs1_d    = bus.in_rs1;
            rs2_d    = bus.in_rs2;
            imm_en_d = bus.in_imm_en;
        end else if (valid_q && bus.out_ready) begin
            // Data outputs keep their last values after a drain.
            valid_d = 1'b0;
        end else if (valid_q && wb_hit) begin
            if (bus.wb_addr == rs1_q) begin
                a_d = bus.wb_data;
            end
            if ((bus.wb_addr == rs2_q) && !imm_en_q) begin
                b_d = bus.wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            op_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_en_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_en_q <= imm_en_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_op    = op_q;
    assign bus.out_rd    = rd_q;
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized
// traffic compared against a behavioural model of the stage.
module tb_operand_fetch;
    import cpu_pkg::*;

    localparam int unsigned W    = DEF_W;
    localparam int unsigned OPW  = DEF_OPW;
    localparam int unsigned NREG = DEF_NREG;
    localparam int unsigned RA   = DEF_RA;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_fetch_if #(.W(W), .OPW(OPW), .NREG(NREG)) bus ();

    operand_fetch #(.W(W), .OPW(OPW), .NREG(NREG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: register array plus the contents of the ALU slot.
    logic [W-1:0]   m_rf [NREG];
    logic           m_valid;
    logic [OPW-1:0] m_op;
    logic [RA-1:0]  m_rd;
    logic [W-1:0]   m_a;
    logic [W-1:0]   m_b;
    logic [RA-1:0]  m_rs1;
    logic [RA-1:0]  m_rs2;
    logic           m_imm;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_rf[i] = '0;
        m_valid = 1'b0; m_op = '0; m_rd = '0; m_a = '0; m_b = '0;
        m_rs1 = '0; m_rs2 = '0; m_imm = 1'b0;
    endtask

    // Value an instruction sees for source r, including same-cycle write-back.
    function automatic logic [W-1:0] m_src(input logic [RA-1:0] r);
        if (r == 0) return '0;
        if (bus.wb_en && bus.wb_addr == r) return bus.wb_data;
        return m_rf[r];
    endfunction

    task automatic model_update();
        logic rdy;
        logic wbh;
        rdy = !m_valid || bus.out_ready;
        wbh = bus.wb_en && (bus.wb_addr != 0);
        if (bus.in_valid && rdy) begin
            m_valid = 1'b1;
            m_op    = bus.in_op;
            m_rd    = bus.in_rd;
            m_a     = m_src(bus.in_rs1);
            m_b     = bus.in_imm_en ? bus.in_imm : m_src(bus.in_rs2);
            m_rs1   = bus.in_rs1;
            m_rs2   = bus.in_rs2;
            m_imm   = bus.in_imm_en;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end else if (m_valid && wbh) begin
            if (bus.wb_addr == m_rs1) m_a = bus.wb_data;
            if (bus.wb_addr == m_rs2 && !m_imm) m_b = bus.wb_data;
        end
        if (wbh) m_rf[bus.wb_addr] = bus.wb_data;
    endtask

    // One clock: advance the model at the edge, return 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        #1;
    endtask

    task automatic set_in(input logic v, input logic [OPW-1:0] op, input logic [RA-1:0] rd,
                          input logic [RA-1:0] rs1, input logic [RA-1:0] rs2,
                          input logic imm_en, input logic [W-1:0] imm);
        bus.in_valid = v; bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1;
        bus.in_rs2 = rs2; bus.in_imm_en = imm_en; bus.in_imm = imm;
    endtask

    task automatic set_wb(input logic en, input logic [RA-1:0] addr, input logic [W-1:0] data);
        bus.wb_en = en; bus.wb_addr = addr; bus.wb_data = data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b0, '0, '0, '0, '0, 1'b0, '0);
        set_wb(1'b0, '0, '0);
        bus.out_ready = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
        checks++;
        if ({bus.out_op, bus.out_rd, bus.out_a, bus.out_b} !== '0) begin
            errors++; $display("FAIL reset_data got op=%h rd=%h a=%h b=%h exp all 0",
                               bus.out_op, bus.out_rd, bus.out_a, bus.out_b);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        step(); step();
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        set_wb(1'b1, 3'd3, 8'h15);
        step();
        set_wb(1'b0, '0, '0);
        set_in(1'b1, OP_ADD, 3'd1, 3'd3, 3'd0, 1'b0, 8'h00);
        step();
        checks++;
        if ({bus.out_valid, bus.out_op, bus.out_a, bus.out_b} !== {1'b1, 3'b000, 8'h15, 8'h00}) begin
            errors++; $display("FAIL add_r3 got v=%b op=%h a=%h b=%h exp v=1 op=0 a=15 b=00",
                               bus.out_valid, bus.out_op, bus.out_a, bus.out_b);
        end
        // XOR with write-back to its own sources in the same cycle.
        set_in(1'b1, OP_XOR, 3'd2, 3'd2, 3'd2, 1'b0, 8'h00);
        set_wb(1'b1, 3'd2, 8'hA5);
        step();
        set_wb(1'b0, '0, '0);
        checks++;
        if ({bus.out_op, bus.out_a, bus.out_b} !== {3'b011, 8'hA5, 8'hA5}) begin
            errors++; $display("FAIL xor_bypass got op=%h a=%h b=%h exp op=3 a=a5 b=a5",
                               bus.out_op, bus.out_a, bus.out_b);
        end
        // Writes to r0 are dropped.
        set_in(1'b0, '0, '0, '0, '0, 1'b0, '0);
        set_wb(1'b1, 3'd0, 8'hFF);
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", bus.out_valid); end
        set_wb(1'b0, '0, '0);
        set_in(1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 1'b0, 8'h00);
        step();
        checks++;
        if (bus.out_a !== 8'h00) begin errors++; $display("FAIL r0_read got %h exp 00", bus.out_a); end
        set_in(1'b1, OP_SHL, 3'd7, 3'd3, 3'd2, 1'b1, 8'h40);
        step();
        checks++;
        if ({bus.out_op, bus.out_rd, bus.out_a, bus.out_b} !== {3'b010, 3'd7, 8'h15, 8'h40}) begin
            errors++; $display("FAIL shl_imm got op=%h rd=%h a=%h b=%h exp op=2 rd=7 a=15 b=40",
                               bus.out_op, bus.out_rd, bus.out_a, bus.out_b);
        end
    endtask

    task automatic test_held_refresh();
        set_in(1'b0, '0, '0, '0, '0, 1'b0, '0);
        set_wb(1'b1, 3'd4, 8'h11);
        step();
        set_wb(1'b0, '0, '0);
        set_in(1'b1, OP_ADD, 3'd6, 3'd4, 3'd5, 1'b0, 8'h00);
        bus.out_ready = 1'b0;
        step();
        // Stalled: new instruction must not get in; held rs2 refreshes.
        set_in(1'b1, OP_XOR, 3'd1, 3'd1, 3'd1, 1'b0, 8'h00);
        set_wb(1'b1, 3'd5, 8'h3C);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b exp 0", bus.in_ready); end
        step();
        checks++;
        if ({bus.out_valid, bus.out_op, bus.out_rd, bus.out_a, bus.out_b} !== {1'b1, 3'b000, 3'd6, 8'h11, 8'h3C}) begin
            errors++; $display("FAIL refresh_b got v=%b op=%h rd=%h a=%h b=%h exp v=1 op=0 rd=6 a=11 b=3c",
                               bus.out_valid, bus.out_op, bus.out_rd, bus.out_a, bus.out_b);
        end
        set_wb(1'b1, 3'd4, 8'h22);
        step();
        checks++;
        if ({bus.out_a, bus.out_b} !== {8'h22, 8'h3C}) begin
            errors++; $display("FAIL refresh_a got a=%h b=%h exp a=22 b=3c", bus.out_a, bus.out_b);
        end
        // Consume and accept together: immediate instruction replaces held one.
        set_wb(1'b0, '0, '0);
        bus.out_ready = 1'b1;
        set_in(1'b1, OP_SHR, 3'd6, 3'd4, 3'd5, 1'b1, 8'h99);
        step();
        checks++;
        if ({bus.out_valid, bus.out_op, bus.out_a, bus.out_b} !== {1'b1, 3'b001, 8'h22, 8'h99}) begin
            errors++; $display("FAIL replace got v=%b op=%h a=%h b=%h exp v=1 op=1 a=22 b=99",
                               bus.out_valid, bus.out_op, bus.out_a, bus.out_b);
        end
        bus.out_ready = 1'b0;
        set_in(1'b0, '0, '0, '0, '0, 1'b0, '0);
        set_wb(1'b1, 3'd5, 8'h77);
        step();
        checks++;
        if ({bus.out_valid, bus.out_b, bus.in_ready} !== {1'b1, 8'h99, 1'b0}) begin
            errors++; $display("FAIL imm_no_refresh got v=%b b=%h in_ready=%b exp v=1 b=99 in_ready=0",
                               bus.out_valid, bus.out_b, bus.in_ready);
        end
        set_wb(1'b0, '0, '0);
        bus.out_ready = 1'b1;
        step();
        checks++;
        if ({bus.out_valid, bus.out_a, bus.out_b} !== {1'b0, 8'h22, 8'h99}) begin
            errors++; $display("FAIL drain_hold got v=%b a=%h b=%h exp v=0 a=22 b=99",
                               bus.out_valid, bus.out_a, bus.out_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  exp_a [4];
        logic [RA-1:0] srcs  [4];
        exp_a[0] = 8'hA5; exp_a[1] = 8'h15; exp_a[2] = 8'h22; exp_a[3] = 8'h77;
        srcs[0]  = 3'd2;  srcs[1]  = 3'd3;  srcs[2]  = 3'd4;  srcs[3]  = 3'd5;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, OPW'(i), RA'(i + 1), srcs[i], 3'd0, 1'b1, W'(8'h10 * i + 1));
            step();
            checks++;
            if ({bus.out_valid, bus.out_op, bus.out_rd, bus.out_a, bus.out_b}
                !== {1'b1, OPW'(i), RA'(i + 1), exp_a[i], W'(8'h10 * i + 1)}) begin
                errors++; $display("FAIL b2b[%0d] got v=%b op=%h rd=%h a=%h b=%h exp v=1 op=%h rd=%h a=%h b=%h",
                                   i, bus.out_valid, bus.out_op, bus.out_rd, bus.out_a, bus.out_b,
                                   OPW'(i), RA'(i + 1), exp_a[i], W'(8'h10 * i + 1));
            end
        end
        set_in(1'b0, '0, '0, '0, '0, 1'b0, '0);
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 9) < 6, OPW'($urandom), RA'($urandom), RA'($urandom_range(0, NREG - 1)),
                   RA'($urandom_range(0, NREG - 1)), 1'($urandom), W'($urandom));
            set_wb($urandom_range(0, 1) == 1, RA'($urandom_range(0, NREG - 1)), W'($urandom));
            bus.out_ready = $urandom_range(0, 9) < 7;
            #1;
            checks++;
            if (bus.in_ready !== (!m_valid || bus.out_ready)) begin
                errors++; $display("FAIL rand_in_ready[%0d] got %b exp %b", n, bus.in_ready, !m_valid || bus.out_ready);
            end
            step();
            checks++;
            if ({bus.out_valid, bus.out_op, bus.out_rd, bus.out_a, bus.out_b} !== {m_valid, m_op, m_rd, m_a, m_b}) begin
                errors++; $display("FAIL rand_slot[%0d] got v=%b op=%h rd=%h a=%h b=%h exp v=%b op=%h rd=%h a=%h b=%h",
                                   n, bus.out_valid, bus.out_op, bus.out_rd, bus.out_a, bus.out_b,
                                   m_valid, m_op, m_rd, m_a, m_b);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        set_wb(1'b1, 3'd5, 8'h5A);
        set_in(1'b1, OP_XOR, 3'd2, 3'd5, 3'd5, 1'b0, 8'h00);
        bus.out_ready = 1'b1;
        step();
        set_wb(1'b0, '0, '0);
        bus.out_ready = 1'b0;
        step();
        checks++;
        if ({bus.out_valid, bus.out_a} !== {1'b1, 8'h5A}) begin
            errors++; $display("FAIL pre_reset got v=%b a=%h exp v=1 a=5a", bus.out_valid, bus.out_a);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.out_valid, bus.out_op, bus.out_rd, bus.out_a, bus.out_b} !== '0) begin
            errors++; $display("FAIL async_reset got v=%b op=%h rd=%h a=%h b=%h exp all 0",
                               bus.out_valid, bus.out_op, bus.out_rd, bus.out_a, bus.out_b);
        end
        step();
        rst_n = 1'b1;
        #2;
        bus.out_ready = 1'b1;
        set_in(1'b1, OP_ADD, 3'd1, 3'd5, 3'd3, 1'b0, 8'h00);
        step();
        checks++;
        if ({bus.out_valid, bus.out_a, bus.out_b} !== {1'b1, 8'h00, 8'h00}) begin
            errors++; $display("FAIL post_reset_rf got v=%b a=%h b=%h exp v=1 a=00 b=00",
                               bus.out_valid, bus.out_a, bus.out_b);
        end
        set_in(1'b0, '0, '0, '0, '0, 1'b0, '0);
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_held_refresh();
        test_back_to_back();
        test_random();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
